// File: rtl/adc_scan_scheduler.sv
// Round-robin channel scheduler for an 8-channel ADC with a one-frame result pipeline.
// Averages 2^AVG_LOG2 results per channel into a readable register bank.
module adc_scan_scheduler #(
    parameter int unsigned FRAME_CYCLES = 17,
    parameter int unsigned CAPTURE_AT   = 16,
    parameter int unsigned AVG_LOG2     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  chan_mask,
    input  logic [11:0] adc_result,
    output logic [2:0]  adc_chan,
    output logic        sample_valid,
    output logic [2:0]  sample_chan,
    output logic [11:0] sample_data,
    output logic        scan_done,
    input  logic [2:0]  rd_chan,
    output logic [11:0] rd_data
);
    localparam int unsigned FW         = $clog2(FRAME_CYCLES);
    localparam logic [3:0]  DWELL_LAST = 4'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t        state, state_next;
    logic [FW-1:0] frame_cnt;
    logic [3:0]    dwell_cnt;
    logic [15:0]   acc;
    logic [2:0]    prev_chan;
    logic          prev_valid;
    logic          prev_last;
    logic [11:0]   bank [8];

    logic          wrap, capture;
    logic [2:0]    lowest_chan, next_chan, top_chan;
    logic [15:0]   acc_sum;
    logic [11:0]   avg;

    assign wrap    = (frame_cnt == FW'(FRAME_CYCLES - 1));
    assign capture = (frame_cnt == FW'(CAPTURE_AT));
    assign acc_sum = acc + 16'(adc_result);
    assign avg     = 12'(acc_sum >> AVG_LOG2);
    assign rd_data = bank[rd_chan];

    always_comb begin
        lowest_chan = '0;
        top_chan    = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (chan_mask[3'(7 - i)]) lowest_chan = 3'(7 - i);
            if (chan_mask[3'(i)]) top_chan = 3'(i);
        end
        next_chan = lowest_chan;
        for (int unsigned i = 0; i < 8; i++) begin
            if (chan_mask[3'(7 - i)] && (3'(7 - i) > adc_chan)) next_chan = 3'(7 - i);
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (enable && (chan_mask != '0)) state_next = PRIME;
            PRIME, RUN: begin
                if (!enable)                           state_next = IDLE;
                else if (wrap && (chan_mask == '0))    state_next = IDLE;
                else if (wrap)                         state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            adc_chan     <= '0;
            frame_cnt    <= '0;
            dwell_cnt    <= '0;
            acc          <= '0;
            prev_chan    <= '0;
            prev_valid   <= 1'b0;
            prev_last    <= 1'b0;
            sample_valid <= 1'b0;
            sample_chan  <= '0;
            sample_data  <= '0;
            scan_done    <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) bank[3'(i)] <= '0;
        end else begin
            state        <= state_next;
            sample_valid <= 1'b0;
            scan_done    <= 1'b0;
            if ((state == IDLE) || !enable) begin
                frame_cnt  <= '0;
                dwell_cnt  <= '0;
                acc        <= '0;
                prev_valid <= 1'b0;
                if (state_next == PRIME) adc_chan <= lowest_chan;
            end else begin
                frame_cnt <= wrap ? '0 : frame_cnt + 1'b1;
                // Only results of RUN-frame requests count; prev_last marks the
                // final request of a dwell, so its result closes that channel's group.
                if ((state == RUN) && capture && prev_valid) begin
                    if (prev_last) begin
                        bank[prev_chan] <= avg;
                        acc             <= '0;
                        sample_valid    <= 1'b1;
                        sample_chan     <= prev_chan;
                        sample_data     <= avg;
                        scan_done       <= (prev_chan == top_chan);
                    end else begin
                        acc <= acc_sum;
                    end
                end
                if (wrap) begin
                    prev_chan  <= adc_chan;
                    prev_valid <= (state == RUN);
                    prev_last  <= (dwell_cnt == DWELL_LAST);
                    if ((state == RUN) && (chan_mask != '0)) begin
                        if (dwell_cnt == DWELL_LAST) begin
                            dwell_cnt <= '0;
                            adc_chan  <= next_chan;
                        end else begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler: frame-aligned converter model plus a
// scoreboard of expected averaged samples.
module tb_adc_scan_scheduler;
    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  chan_mask;
    logic [11:0] adc_result;
    logic [2:0]  adc_chan;
    logic        sample_valid;
    logic [2:0]  sample_chan;
    logic [11:0] sample_data;
    logic        scan_done;
    logic [2:0]  rd_chan;
    logic [11:0] rd_data;

    adc_scan_scheduler #(.FRAME_CYCLES(17), .CAPTURE_AT(16), .AVG_LOG2(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask),
        .adc_result(adc_result), .adc_chan(adc_chan), .sample_valid(sample_valid),
        .sample_chan(sample_chan), .sample_data(sample_data), .scan_done(scan_done),
        .rd_chan(rd_chan), .rd_data(rd_data)
    );

    typedef struct packed {
        logic [2:0]  chan;
        logic [11:0] data;
        logic        done;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [11:0] rq[$];
    int          exp_seq[$];
    logic        tb_run = 1'b0;
    logic        tb_on  = 1'b0;
    int          tb_fc  = 0;
    int          first;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Converter: the result presented during frame k answers the request of frame k-1.
    always @(posedge clk) begin
        if (!tb_run) begin
            tb_on <= 1'b0;
            tb_fc <= 0;
        end else if (!tb_on) begin
            tb_on <= 1'b1;
            tb_fc <= 0;
        end else if (tb_fc == 16) begin
            tb_fc <= 0;
            if (rq.size() > 0) adc_result <= rq.pop_front();
            else               adc_result <= 12'(100 + 16 * int'(adc_chan));
        end else begin
            tb_fc <= tb_fc + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sample_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_sample_valid", 32'(sample_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sample_chan", 32'(sample_chan), 32'(e.chan));
                chk("sample_data", 32'(sample_data), 32'(e.data));
                chk("scan_done", 32'(scan_done), 32'(e.done));
            end
        end else if (scan_done) begin
            chk("scan_done_without_valid", 32'(scan_done), 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] m);
        chan_mask = m;
        enable    = 1'b1;
        tb_run    = 1'b1;
    endtask

    task automatic stop();
        enable = 1'b0;
        tb_run = 1'b0;
        rq.delete();
        step();
        step();
    endtask

    // Runs whole frames from the first edge after start(); first = edge index of the first valid.
    task automatic run_frames(input int nframes, output int first_valid);
        first_valid = -1;
        for (int f = 0; f < nframes; f++) begin
            for (int c = 0; c < 17; c++) begin
                step();
                if (sample_valid && (first_valid < 0)) first_valid = f * 17 + c;
                if ((c == 8) && (f < exp_seq.size())) chk("adc_chan_seq", 32'(adc_chan), 32'(exp_seq[f]));
            end
        end
    endtask

    task automatic check_bank(input int ch, input logic [11:0] v);
        rd_chan = 3'(ch);
        step();
        chk("rd_data", 32'(rd_data), 32'(v));
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        chan_mask  = '0;
        adc_result = '0;
        rd_chan    = '0;

        // Reset and idle outputs
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();
        chk("rst_sample_valid", 32'(sample_valid), 32'd0);
        chk("rst_sample_chan", 32'(sample_chan), 32'd0);
        chk("rst_sample_data", 32'(sample_data), 32'd0);
        chk("rst_scan_done", 32'(scan_done), 32'd0);
        for (int i = 0; i < 8; i++) check_bank(i, 12'd0);
        chk("idle_adc_chan", 32'(adc_chan), 32'd0);

        // Two-channel scan, mask 0x05
        sb.push_back('{chan: 3'd0, data: 12'd100, done: 1'b0});
        sb.push_back('{chan: 3'd2, data: 12'd132, done: 1'b1});
        sb.push_back('{chan: 3'd0, data: 12'd100, done: 1'b0});
        exp_seq = '{0, 0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0, 2, 2};
        start(8'h05);
        run_frames(15, first);
        chk("first_valid_latency", 32'(first), 32'd102);
        stop();
        chk("scan_sb_drained", 32'(sb.size()), 32'd0);
        check_bank(0, 12'd100);
        check_bank(2, 12'd132);

        // Truncating average on channel 3; the first RUN capture answers the stale prime request
        rq = '{12'd4000, 12'd1, 12'd2, 12'd2, 12'd2, 12'd4095, 12'd4095, 12'd4095, 12'd4095};
        sb.push_back('{chan: 3'd3, data: 12'd1, done: 1'b1});
        sb.push_back('{chan: 3'd3, data: 12'd4095, done: 1'b1});
        exp_seq = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
        start(8'h08);
        run_frames(11, first);
        chk("trunc_first_valid", 32'(first), 32'd102);
        stop();
        chk("trunc_sb_drained", 32'(sb.size()), 32'd0);
        check_bank(3, 12'd4095);

        // Mask change 0x03 -> 0x08 during the channel 0 dwell
        sb.push_back('{chan: 3'd0, data: 12'd100, done: 1'b0});
        sb.push_back('{chan: 3'd3, data: 12'd148, done: 1'b1});
        exp_seq = '{0, 0, 0};
        start(8'h03);
        run_frames(3, first);
        chan_mask = 8'h08;
        exp_seq = '{0, 0, 3, 3, 3, 3, 3, 3};
        run_frames(8, first);
        stop();
        chk("mask_sb_drained", 32'(sb.size()), 32'd0);
        check_bank(1, 12'd0);
        check_bank(3, 12'd148);

        // Enable dropped at frame_cnt 5 of the third RUN frame, then re-enabled
        rq = '{12'd4000, 12'd4000};
        exp_seq = '{};
        start(8'h01);
        repeat (57) step();
        enable = 1'b0;
        tb_run = 1'b0;
        rq.delete();
        repeat (30) step();
        chk("drop_adc_chan", 32'(adc_chan), 32'd0);
        chk("drop_sb_empty", 32'(sb.size()), 32'd0);
        check_bank(0, 12'd100);
        rq = '{12'd4000, 12'd8, 12'd8, 12'd8, 12'd8};
        sb.push_back('{chan: 3'd0, data: 12'd8, done: 1'b1});
        exp_seq = '{0, 0, 0, 0, 0, 0, 0};
        start(8'h01);
        run_frames(7, first);
        chk("reenable_first_valid", 32'(first), 32'd102);
        stop();
        chk("reenable_sb_drained", 32'(sb.size()), 32'd0);
        check_bank(0, 12'd8);

        // Reset on the capture cycle of a due average
        start(8'h04);
        repeat (102) step();
        chk("pre_reset_adc_chan", 32'(adc_chan), 32'd2);
        reset  = 1'b1;
        tb_run = 1'b0;
        step();
        chk("reset_sample_valid", 32'(sample_valid), 32'd0);
        chk("reset_adc_chan", 32'(adc_chan), 32'd0);
        enable = 1'b0;
        reset  = 1'b0;
        for (int i = 0; i < 8; i++) check_bank(i, 12'd0);
        repeat (20) step();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
